// File: rtl/result_collector.sv
// result_collector: round-robin gather of finished pixels from 16 engines
// into the frame-buffer write port.
// Ports: clk, rst_n (async, active-low); i_done/i_addr per-engine results;
// o_select drives the colour mux, i_color is its output; o_ack one-hot
// result-taken pulse; o_wr_en/o_wr_addr/o_wr_data with i_wr_ready
// backpressure; o_pix_count/i_count_clr accepted-write counter.
// Optional: define RESULT_COLLECTOR_STATS_EN to enable the pixel counter;
// otherwise o_pix_count reads 0 and i_count_clr is ignored.
module result_collector #(
    parameter int N_ENG   = 16,
    parameter int SEL_W   = 4,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_ENG-1:0]        i_done,
    input  logic [N_ENG*ADDR_W-1:0] i_addr,
    output logic [SEL_W-1:0]        o_select,
    input  logic [COLOR_W-1:0]      i_color,
    output logic [N_ENG-1:0]        o_ack,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [COLOR_W-1:0]      o_wr_data,
    input  logic                    i_wr_ready,
    output logic [31:0]             o_pix_count,
    input  logic                    i_count_clr
);

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_ENG-1:0]   ack_q, ack_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;

    logic               hit;
    logic [SEL_W-1:0]   idx;

    // Rotating search: candidate i is ptr+i (mod N_ENG), so the engine
    // served last is examined last.
    always_comb begin
        logic [SEL_W-1:0] cand;
        hit  = 1'b0;
        idx  = ptr_q;
        cand = '0;
        for (int i = 0; i < N_ENG; i++) begin
            cand = ptr_q + SEL_W'(i);
            if (!hit && i_done[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ack_d   = '0;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            SCAN: begin
                if (hit) begin
                    sel_d   = idx;
                    state_d = CAPTURE;
                end
            end
            // Mux select has settled for a full cycle; latch its output.
            CAPTURE: begin
                data_d       = i_color;
                addr_d       = i_addr[sel_q*ADDR_W +: ADDR_W];
                wr_en_d      = 1'b1;
                ack_d[sel_q] = 1'b1;
                ptr_d        = sel_q + 1'b1;
                state_d      = WRITE;
            end
            WRITE: begin
                if (i_wr_ready) begin
                    wr_en_d = 1'b0;
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_select  = sel_q;
    assign o_ack     = ack_q;
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = addr_q;
    assign o_wr_data = data_q;

`ifdef RESULT_COLLECTOR_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    // Clear has priority over a same-cycle accept.
    always_comb begin
        cnt_d = cnt_q;
        if (i_count_clr)
            cnt_d = '0;
        else if (wr_en_q && i_wr_ready)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_pix_count = cnt_q;
`else
    logic unused_count_clr;
    assign unused_count_clr = i_count_clr;
    assign o_pix_count      = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: table-driven scoreboard bench for result_collector.
// Engine model drops its done flag the cycle after its ack.
module tb_result_collector;

    localparam int N  = 16;
    localparam int AW = 19;
    localparam int CW = 12;
`ifdef RESULT_COLLECTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    i_done;
    logic [N*AW-1:0] i_addr;
    logic [3:0]      o_select;
    logic [CW-1:0]   i_color;
    logic [N-1:0]    o_ack;
    logic            o_wr_en;
    logic [AW-1:0]   o_wr_addr;
    logic [CW-1:0]   o_wr_data;
    logic            i_wr_ready;
    logic [31:0]     o_pix_count;
    logic            i_count_clr;

    logic [AW-1:0] eng_addr [N];
    logic [CW-1:0] eng_col  [N];

    always #5 clk = ~clk;

    always_comb begin
        i_addr = '0;
        for (int k = 0; k < N; k++)
            i_addr[k*AW +: AW] = eng_addr[k];
    end

    assign i_color = eng_col[o_select];

    result_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_done      (i_done),
        .i_addr      (i_addr),
        .o_select    (o_select),
        .i_color     (i_color),
        .o_ack       (o_ack),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_ready  (i_wr_ready),
        .o_pix_count (o_pix_count),
        .i_count_clr (i_count_clr)
    );

    typedef struct {
        logic [15:0] mask;
        int          stall;
        bit          clr;
        int          n;
        logic [15:0] seq;
    } vec_t;

    vec_t tbl [7];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          stall_cfg, stall_left, last_acc, nacc, cur;
    bit          mon, clr_acc, chk_tp;
    int          expq [$];
    logic [31:0] exp_cnt;
    logic [15:0] ack_prev;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        i_done      = i_done & ~ack_prev;
        ack_prev    = o_ack;
        i_count_clr = 1'b0;
        i_wr_ready  = 1'b1;
        if (mon) begin
            if (o_ack != '0) begin
                if (expq.size() == 0) begin
                    chk("extra_ack", {16'h0, o_ack}, 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("ack_grant", {16'h0, o_ack}, 32'(1) << e);
                    cur = e;
                end
            end
            if (o_wr_en) begin
                chk("wr_addr", {13'h0, o_wr_addr}, {13'h0, eng_addr[cur]});
                chk("wr_data", {20'h0, o_wr_data}, {20'h0, eng_col[cur]});
                if (stall_left > 0) begin
                    i_wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    i_count_clr = clr_acc;
                    exp_cnt     = clr_acc ? 32'd0 : exp_cnt + 32'd1;
                    stall_left  = stall_cfg;
                    if (chk_tp && last_acc >= 0)
                        chk("throughput", cyc - last_acc, 3);
                    last_acc = cyc;
                    nacc++;
                end
            end
        end
    endtask

    task automatic run(input logic [15:0] mask, input int stall,
                       input bit clr);
        stall_cfg  = stall;
        stall_left = stall;
        clr_acc    = clr;
        last_acc   = -1;
        nacc       = 0;
        mon        = 1'b1;
        i_done     = i_done | mask;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (expq.size() == 0 && !o_wr_en)
                break;
        end
        if (expq.size() != 0 || o_wr_en) begin
            total++;
            bad++;
            $display("FAIL run_timeout: pending=%0d", expq.size());
            expq.delete();
        end
        repeat (2) tick();
        chk("pix_count", o_pix_count, STATS ? exp_cnt : 32'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            eng_addr[k] = 19'd1000 + 19'(k * 4099);
            eng_col[k]  = {4'(k), 4'hA, ~4'(k)};
        end
        eng_addr[5] = 19'd1234;
        eng_col[5]  = 12'hF80;

        tbl[0] = '{16'h0021, 0,  1'b0, 2, 16'h0050};
        tbl[1] = '{16'h8041, 0,  1'b0, 3, 16'h00F6};
        tbl[2] = '{16'h8000, 3,  1'b0, 1, 16'h000F};
        tbl[3] = '{16'h8001, 0,  1'b0, 2, 16'h00F0};
        tbl[4] = '{16'h0006, 10, 1'b0, 2, 16'h0021};
        tbl[5] = '{16'h0010, 0,  1'b1, 1, 16'h0004};
        tbl[6] = '{16'h0100, 0,  1'b0, 1, 16'h0008};

        rst_n       = 1'b0;
        i_done      = '0;
        i_wr_ready  = 1'b1;
        i_count_clr = 1'b0;
        mon         = 1'b0;
        clr_acc     = 1'b0;
        chk_tp      = 1'b0;
        stall_cfg   = 0;
        stall_left  = 0;
        cur         = 0;
        exp_cnt     = '0;
        ack_prev    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_select", {28'h0, o_select}, 32'h0);
        chk("rst_ack", {16'h0, o_ack}, 32'h0);
        chk("rst_wr_en", {31'h0, o_wr_en}, 32'h0);
        chk("rst_wr_addr", {13'h0, o_wr_addr}, 32'h0);
        chk("rst_wr_data", {20'h0, o_wr_data}, 32'h0);
        chk("rst_pix_count", o_pix_count, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < N; k++)
            expq.push_back(k);
        chk_tp = 1'b1;
        run(16'hFFFF, 0, 1'b0);
        chk_tp = 1'b0;
        chk("all16_writes", nacc, 16);

        expq.push_back(5);
        i_done = i_done | 16'h0020;
        tick();
        chk("lat_select", {28'h0, o_select}, 32'd5);
        chk("lat_ack_early", {16'h0, o_ack}, 32'h0);
        chk("lat_wr_en_early", {31'h0, o_wr_en}, 32'h0);
        tick();
        chk("lat_ack", {16'h0, o_ack}, 32'h0020);
        chk("lat_wr_en", {31'h0, o_wr_en}, 32'h1);
        chk("lat_wr_addr", {13'h0, o_wr_addr}, 32'd1234);
        chk("lat_wr_data", {20'h0, o_wr_data}, 32'hF80);
        tick();
        chk("lat_wr_en_low", {31'h0, o_wr_en}, 32'h0);
        repeat (2) tick();
        chk("single_pix_count", o_pix_count, STATS ? exp_cnt : 32'd0);

        foreach (tbl[v]) begin
            for (int j = 0; j < tbl[v].n; j++)
                expq.push_back(int'((tbl[v].seq >> (4 * j)) & 16'hF));
            run(tbl[v].mask, tbl[v].stall, tbl[v].clr);
            chk($sformatf("vec%0d_writes", v), nacc, tbl[v].n);
        end

        stall_cfg  = 1000;
        stall_left = 1000;
        clr_acc    = 1'b0;
        expq.push_back(3);
        i_done = i_done | 16'h0008;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_wr_en)
                break;
        end
        chk("rstw_setup_wr_en", {31'h0, o_wr_en}, 32'h1);
        i_done = i_done | 16'h0204;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_select", {28'h0, o_select}, 32'h0);
        chk("rstw_ack", {16'h0, o_ack}, 32'h0);
        chk("rstw_wr_en", {31'h0, o_wr_en}, 32'h0);
        chk("rstw_wr_addr", {13'h0, o_wr_addr}, 32'h0);
        chk("rstw_wr_data", {20'h0, o_wr_data}, 32'h0);
        chk("rstw_pix_count", o_pix_count, 32'h0);
        exp_cnt    = '0;
        stall_cfg  = 0;
        stall_left = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        expq.push_back(2);
        expq.push_back(9);
        run(16'h0000, 0, 1'b0);
        chk("rstw_regrant_writes", nacc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
